// File: rtl/rf_write_arb.sv
// Register-file write-port arbiter: mem beats ex beats a 2-entry multiplier queue.
// A starvation counter forces the queue head through, and pend_mask keeps mem/ex writes in WAW order.
module rf_write_arb #(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        Nrst,
  input  logic        mem_valid_i,
  input  logic [3:0]  mem_reg_i,
  input  logic [31:0] mem_data_i,
  output logic        mem_ready_o,
  input  logic        ex_valid_i,
  input  logic [3:0]  ex_reg_i,
  input  logic [31:0] ex_data_i,
  output logic        ex_ready_o,
  input  logic        mul_valid_i,
  input  logic [3:0]  mul_reg_i,
  input  logic [31:0] mul_data_i,
  output logic        mul_ready_o,
  output logic        write_o,
  output logic [3:0]  write_reg_o,
  output logic [31:0] write_data_o,
  output logic [15:0] pend_mask_o,
  output logic [1:0]  mul_cnt_o
);

  localparam logic [1:0] StarveMax = 2'(STARVE_MAX);
  localparam logic [1:0] QueueDepth = 2'(FIFO_DEPTH);

  logic [3:0]  qReg_q  [2];
  logic [31:0] qData_q [2];
  logic [3:0]  qReg_d  [2];
  logic [31:0] qData_d [2];
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  starve_q, starve_d;
  logic        write_q, write_d;
  logic [3:0]  writeReg_q, writeReg_d;
  logic [31:0] writeData_q, writeData_d;

  logic        qNonEmpty;
  logic        forceMul;
  logic [15:0] pendMask;
  logic        memReady, memWin;
  logic        exReady, exWin;
  logic        headWin;
  logic        mulReady, enq;
  logic [1:0]  afterDeq;

  assign qNonEmpty = (cnt_q != 2'd0);
  assign forceMul  = qNonEmpty && (starve_q == StarveMax);

  // Entry 0 is always the head; entry 1 is valid only when two are queued.
  always_comb begin
    pendMask = '0;
    if (cnt_q >= 2'd1) pendMask[qReg_q[0]] = 1'b1;
    if (cnt_q == 2'd2) pendMask[qReg_q[1]] = 1'b1;
  end

  // Readies look only at the other channels and at pend_mask, never at their own valid.
  assign memReady = !forceMul && !pendMask[mem_reg_i];
  assign memWin   = mem_valid_i && memReady;
  assign exReady  = !forceMul && !memWin && !pendMask[ex_reg_i];
  assign exWin    = ex_valid_i && exReady;
  assign headWin  = qNonEmpty && !memWin && !exWin;
  assign mulReady = (cnt_q < QueueDepth);
  assign enq      = mul_valid_i && mulReady;
  assign afterDeq = cnt_q - {1'b0, headWin};

  always_comb begin
    qReg_d  = qReg_q;
    qData_d = qData_q;
    if (headWin) begin
      qReg_d[0]  = qReg_q[1];
      qData_d[0] = qData_q[1];
    end
    if (enq) begin
      qReg_d[afterDeq[0]]  = mul_reg_i;
      qData_d[afterDeq[0]] = mul_data_i;
    end
    cnt_d = afterDeq + {1'b0, enq};
  end

  always_comb begin
    starve_d = starve_q;
    if (!qNonEmpty || headWin) begin
      starve_d = 2'd0;
    end else if (starve_q != StarveMax) begin
      starve_d = starve_q + 2'd1;
    end
  end

  // The data registers hold their last value when nobody wins.
  always_comb begin
    write_d     = memWin || exWin || headWin;
    writeReg_d  = writeReg_q;
    writeData_d = writeData_q;
    if (memWin) begin
      writeReg_d  = mem_reg_i;
      writeData_d = mem_data_i;
    end else if (exWin) begin
      writeReg_d  = ex_reg_i;
      writeData_d = ex_data_i;
    end else if (headWin) begin
      writeReg_d  = qReg_q[0];
      writeData_d = qData_q[0];
    end
  end

  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      qReg_q[0]   <= '0;
      qReg_q[1]   <= '0;
      qData_q[0]  <= '0;
      qData_q[1]  <= '0;
      cnt_q       <= '0;
      starve_q    <= '0;
      write_q     <= 1'b0;
      writeReg_q  <= '0;
      writeData_q <= '0;
    end else begin
      qReg_q      <= qReg_d;
      qData_q     <= qData_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      write_q     <= write_d;
      writeReg_q  <= writeReg_d;
      writeData_q <= writeData_d;
    end
  end

  assign mem_ready_o  = memReady;
  assign ex_ready_o   = exReady;
  assign mul_ready_o  = mulReady;
  assign write_o      = write_q;
  assign write_reg_o  = writeReg_q;
  assign write_data_o = writeData_q;
  assign pend_mask_o  = pendMask;
  assign mul_cnt_o    = cnt_q;

endmodule

// File: tb/tb_rf_write_arb.sv
// Bench for rf_write_arb: a table of one-cycle vectors with hand-computed expectations,
// followed by hand-written full-queue and mid-operation reset sequences.
module tb_rf_write_arb;

  logic        clk;
  logic        Nrst;
  logic        mem_valid, ex_valid, mul_valid;
  logic [3:0]  mem_reg, ex_reg, mul_reg;
  logic [31:0] mem_data, ex_data, mul_data;
  logic        mem_ready, ex_ready, mul_ready;
  logic        write;
  logic [3:0]  write_reg;
  logic [31:0] write_data;
  logic [15:0] pend_mask;
  logic [1:0]  mul_cnt;

  int assertCount = 0;
  int failCount   = 0;

  rf_write_arb #(.FIFO_DEPTH(2), .STARVE_MAX(3)) dut (
    .clk(clk), .Nrst(Nrst),
    .mem_valid_i(mem_valid), .mem_reg_i(mem_reg), .mem_data_i(mem_data), .mem_ready_o(mem_ready),
    .ex_valid_i(ex_valid), .ex_reg_i(ex_reg), .ex_data_i(ex_data), .ex_ready_o(ex_ready),
    .mul_valid_i(mul_valid), .mul_reg_i(mul_reg), .mul_data_i(mul_data), .mul_ready_o(mul_ready),
    .write_o(write), .write_reg_o(write_reg), .write_data_o(write_data),
    .pend_mask_o(pend_mask), .mul_cnt_o(mul_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    logic        mv;
    logic [3:0]  mr;
    logic [31:0] md;
    logic        ev;
    logic [3:0]  er;
    logic [31:0] ed;
    logic        uv;
    logic [3:0]  ur;
    logic [31:0] ud;
    logic        xMemRdy;
    logic        xExRdy;
    logic        xMulRdy;
    logic        xWr;
    logic [3:0]  xReg;
    logic [31:0] xData;
    logic [15:0] xPend;
    logic [1:0]  xCnt;
  } vec_t;

  localparam int NumVecs = 25;
  vec_t vecs [NumVecs];

  function automatic vec_t mkVec(input int mv, input int mr, input logic [31:0] md,
                                 input int ev, input int er, input logic [31:0] ed,
                                 input int uv, input int ur, input logic [31:0] ud,
                                 input int xm, input int xe, input int xu,
                                 input int xw, input int xr, input logic [31:0] xd,
                                 input int xp, input int xc);
    vec_t v;
    v.mv = 1'(mv);  v.mr = 4'(mr);  v.md = md;
    v.ev = 1'(ev);  v.er = 4'(er);  v.ed = ed;
    v.uv = 1'(uv);  v.ur = 4'(ur);  v.ud = ud;
    v.xMemRdy = 1'(xm);  v.xExRdy = 1'(xe);  v.xMulRdy = 1'(xu);
    v.xWr = 1'(xw);  v.xReg = 4'(xr);  v.xData = xd;
    v.xPend = 16'(xp);  v.xCnt = 2'(xc);
    return v;
  endfunction

  function automatic vec_t stim(input int mv, input int mr, input logic [31:0] md,
                                input int ev, input int er, input logic [31:0] ed,
                                input int uv, input int ur, input logic [31:0] ud);
    return mkVec(mv, mr, md, ev, er, ed, uv, ur, ud, 0, 0, 0, 0, 0, 32'h0, 0, 0);
  endfunction

  task automatic applyStimulus(input vec_t v);
    mem_valid = v.mv;  mem_reg = v.mr;  mem_data = v.md;
    ex_valid  = v.ev;  ex_reg  = v.er;  ex_data  = v.ed;
    mul_valid = v.uv;  mul_reg = v.ur;  mul_data = v.ud;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkVector(input int idx, input vec_t v);
    checkOutput($sformatf("vec%0d.mem_ready", idx), 32'(mem_ready), 32'(v.xMemRdy));
    checkOutput($sformatf("vec%0d.ex_ready", idx), 32'(ex_ready), 32'(v.xExRdy));
    checkOutput($sformatf("vec%0d.mul_ready", idx), 32'(mul_ready), 32'(v.xMulRdy));
    checkOutput($sformatf("vec%0d.write", idx), 32'(write), 32'(v.xWr));
    checkOutput($sformatf("vec%0d.write_reg", idx), 32'(write_reg), 32'(v.xReg));
    checkOutput($sformatf("vec%0d.write_data", idx), write_data, v.xData);
    checkOutput($sformatf("vec%0d.pend_mask", idx), 32'(pend_mask), 32'(v.xPend));
    checkOutput($sformatf("vec%0d.mul_cnt", idx), 32'(mul_cnt), 32'(v.xCnt));
  endtask

  // Each row is driven for one cycle; expected write fields reflect the previous row's winner.
  initial begin
    //                mem            ex                    mul          rdy m/e/u  wr reg data          pend     cnt
    vecs[0]  = mkVec(1, 3, 32'hA5A5A5A5, 1, 4, 32'h11111111, 0, 0, 32'h0,  1, 0, 1,  0, 0, 32'h0,          16'h0000, 0);
    vecs[1]  = mkVec(0, 0, 32'h0,        1, 4, 32'h11111111, 0, 0, 32'h0,  1, 1, 1,  1, 3, 32'hA5A5A5A5,   16'h0000, 0);
    vecs[2]  = mkVec(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,  1, 1, 1,  1, 4, 32'h11111111,   16'h0000, 0);
    vecs[3]  = mkVec(0, 0, 32'h0,        1, 8, 32'hE8,       1, 5, 32'h55, 1, 1, 1,  0, 4, 32'h11111111,   16'h0000, 0);
    vecs[4]  = mkVec(0, 0, 32'h0,        1, 9, 32'hE9,       1, 6, 32'h66, 1, 1, 1,  1, 8, 32'hE8,         16'h0020, 1);
    vecs[5]  = mkVec(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,  1, 1, 0,  1, 9, 32'hE9,         16'h0060, 2);
    vecs[6]  = mkVec(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,  1, 1, 1,  1, 5, 32'h55,         16'h0040, 1);
    vecs[7]  = mkVec(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,  1, 1, 1,  1, 6, 32'h66,         16'h0000, 0);
    vecs[8]  = mkVec(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,  1, 1, 1,  0, 6, 32'h66,         16'h0000, 0);
    vecs[9]  = mkVec(0, 0, 32'h0,        0, 0, 32'h0,        1, 7, 32'h77, 1, 1, 1,  0, 6, 32'h66,         16'h0000, 0);
    vecs[10] = mkVec(1, 1, 32'hC0DE0001, 0, 0, 32'h0,        0, 0, 32'h0,  1, 0, 1,  0, 6, 32'h66,         16'h0080, 1);
    vecs[11] = mkVec(1, 2, 32'hC0DE0002, 0, 0, 32'h0,        0, 0, 32'h0,  1, 0, 1,  1, 1, 32'hC0DE0001,   16'h0080, 1);
    vecs[12] = mkVec(1, 3, 32'hC0DE0003, 0, 0, 32'h0,        0, 0, 32'h0,  1, 0, 1,  1, 2, 32'hC0DE0002,   16'h0080, 1);
    vecs[13] = mkVec(1, 4, 32'hC0DE0004, 0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 1,  1, 3, 32'hC0DE0003,   16'h0080, 1);
    vecs[14] = mkVec(1, 4, 32'hC0DE0004, 0, 0, 32'h0,        0, 0, 32'h0,  1, 0, 1,  1, 7, 32'h77,         16'h0000, 0);
    vecs[15] = mkVec(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,  1, 1, 1,  1, 4, 32'hC0DE0004,   16'h0000, 0);
    vecs[16] = mkVec(0, 0, 32'h0,        0, 0, 32'h0,        1, 2, 32'h22, 1, 1, 1,  0, 4, 32'hC0DE0004,   16'h0000, 0);
    vecs[17] = mkVec(0, 0, 32'h0,        1, 2, 32'hEE22,     0, 0, 32'h0,  1, 0, 1,  0, 4, 32'hC0DE0004,   16'h0004, 1);
    vecs[18] = mkVec(0, 0, 32'h0,        1, 2, 32'hEE22,     0, 0, 32'h0,  1, 1, 1,  1, 2, 32'h22,         16'h0000, 0);
    vecs[19] = mkVec(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,  1, 1, 1,  1, 2, 32'hEE22,       16'h0000, 0);
    vecs[20] = mkVec(0, 0, 32'h0,        0, 0, 32'h0,        1, 10, 32'hAA, 1, 1, 1, 0, 2, 32'hEE22,       16'h0000, 0);
    vecs[21] = mkVec(1, 10, 32'hC0DE000A, 1, 11, 32'hEB,     0, 0, 32'h0,  0, 1, 1,  0, 2, 32'hEE22,       16'h0400, 1);
    vecs[22] = mkVec(1, 10, 32'hC0DE000A, 0, 0, 32'h0,       0, 0, 32'h0,  0, 1, 1,  1, 11, 32'hEB,        16'h0400, 1);
    vecs[23] = mkVec(1, 10, 32'hC0DE000A, 0, 0, 32'h0,       0, 0, 32'h0,  1, 0, 1,  1, 10, 32'hAA,        16'h0000, 0);
    vecs[24] = mkVec(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,  1, 1, 1,  1, 10, 32'hC0DE000A,  16'h0000, 0);

    Nrst = 1'b0;
    applyStimulus(stim(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0));
    #2;
    checkOutput("reset.write", 32'(write), 32'h0);
    checkOutput("reset.write_reg", 32'(write_reg), 32'h0);
    checkOutput("reset.write_data", write_data, 32'h0);
    checkOutput("reset.mul_cnt", 32'(mul_cnt), 32'h0);
    checkOutput("reset.pend_mask", 32'(pend_mask), 32'h0);
    checkOutput("reset.mem_ready", 32'(mem_ready), 32'h1);
    checkOutput("reset.ex_ready", 32'(ex_ready), 32'h1);
    checkOutput("reset.mul_ready", 32'(mul_ready), 32'h1);
    @(negedge clk);
    Nrst = 1'b1;

    for (int i = 0; i < NumVecs; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkVector(i, vecs[i]);
    end

    // Full queue dequeues while a new mul request waits: it is refused until the next cycle.
    @(negedge clk);
    applyStimulus(stim(0, 0, 32'h0, 1, 12, 32'hEC, 1, 13, 32'hDD));
    @(negedge clk);
    applyStimulus(stim(0, 0, 32'h0, 1, 12, 32'hEC, 1, 14, 32'hEE));
    @(negedge clk);
    applyStimulus(stim(0, 0, 32'h0, 0, 0, 32'h0, 1, 15, 32'hFF));
    #1;
    checkOutput("full.mul_ready", 32'(mul_ready), 32'h0);
    checkOutput("full.mul_cnt", 32'(mul_cnt), 32'h2);
    checkOutput("full.pend_mask", 32'(pend_mask), 32'h6000);
    @(negedge clk);
    #1;
    checkOutput("refill.mul_ready", 32'(mul_ready), 32'h1);
    checkOutput("refill.mul_cnt", 32'(mul_cnt), 32'h1);
    checkOutput("refill.pend_mask", 32'(pend_mask), 32'h4000);
    checkOutput("refill.write_reg", 32'(write_reg), 32'hD);
    checkOutput("refill.write_data", write_data, 32'hDD);
    @(negedge clk);
    applyStimulus(stim(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0));
    #1;
    checkOutput("order1.mul_cnt", 32'(mul_cnt), 32'h1);
    checkOutput("order1.pend_mask", 32'(pend_mask), 32'h8000);
    checkOutput("order1.write_reg", 32'(write_reg), 32'hE);
    checkOutput("order1.write_data", write_data, 32'hEE);
    @(negedge clk);
    #1;
    checkOutput("order2.write", 32'(write), 32'h1);
    checkOutput("order2.write_reg", 32'(write_reg), 32'hF);
    checkOutput("order2.write_data", write_data, 32'hFF);
    checkOutput("order2.mul_cnt", 32'(mul_cnt), 32'h0);

    // Reset with two queued entries drops them and clears the port at once.
    @(negedge clk);
    applyStimulus(stim(0, 0, 32'h0, 1, 12, 32'h1EC, 1, 1, 32'h101));
    @(negedge clk);
    applyStimulus(stim(0, 0, 32'h0, 1, 12, 32'h2EC, 1, 2, 32'h202));
    @(negedge clk);
    applyStimulus(stim(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0));
    #1;
    checkOutput("prerst.mul_cnt", 32'(mul_cnt), 32'h2);
    checkOutput("prerst.write", 32'(write), 32'h1);
    checkOutput("prerst.pend_mask", 32'(pend_mask), 32'h0006);
    Nrst = 1'b0;
    #1;
    checkOutput("rst.write", 32'(write), 32'h0);
    checkOutput("rst.mul_cnt", 32'(mul_cnt), 32'h0);
    checkOutput("rst.pend_mask", 32'(pend_mask), 32'h0);
    checkOutput("rst.write_reg", 32'(write_reg), 32'h0);
    checkOutput("rst.write_data", write_data, 32'h0);
    checkOutput("rst.mul_ready", 32'(mul_ready), 32'h1);
    #1;
    Nrst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("postrst%0d.write", k), 32'(write), 32'h0);
      checkOutput($sformatf("postrst%0d.mul_cnt", k), 32'(mul_cnt), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
